// File: rtl/fm_op_seq.sv
// Operator-slot sequencer: walks every operator slot once per accepted sample tick and derives
// per-operator kon / restart / op_reset. Optional macro FM_SEQ_OVERRUN_CNT_EN adds overrun_cnt.
module fm_op_seq #(
    parameter int NUM_OPS     = 36,
    parameter int SLOT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sample_tick,
    input  logic                   clr_req,
    input  logic [NUM_OPS/2-1:0]   kon_ch,
    output logic [5:0]             op_sel,
    output logic                   next,
    output logic                   op_reset,
    output logic                   restart,
    output logic                   kon,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
`ifdef FM_SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]             overrun_cnt
`endif
);

    localparam int              CW       = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(SLOT_CYCLES - 1);
    localparam logic [5:0]      LAST_OP  = 6'(NUM_OPS - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t               r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic [5:0]           r_op_sel, w_op_sel_next;
    logic                 r_commit, w_commit_next;
    logic                 r_op_reset, w_op_reset_next;
    logic                 r_restart, w_restart_next;
    logic                 r_kon, w_kon_next;
    logic                 r_busy, w_busy_next;
    logic                 r_frame_done, w_frame_done_next;
    logic                 r_overrun, w_overrun_next;
    logic                 r_frame_clr, w_frame_clr_next;
    logic                 r_clr_pending, w_clr_pending_next;
    logic [NUM_OPS-1:0]   r_kon_prev, w_kon_prev_next;

    logic                 w_slot_load;
    logic [5:0]           w_slot_op;
    logic                 w_slot_clr;
    logic                 w_prev_we;
    logic                 w_ovr_tick;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_op_sel      <= '0;
            r_commit      <= 1'b0;
            r_op_reset    <= 1'b0;
            r_restart     <= 1'b0;
            r_kon         <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_clr   <= 1'b0;
            r_clr_pending <= 1'b1;
            r_kon_prev    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_op_sel      <= w_op_sel_next;
            r_commit      <= w_commit_next;
            r_op_reset    <= w_op_reset_next;
            r_restart     <= w_restart_next;
            r_kon         <= w_kon_next;
            r_busy        <= w_busy_next;
            r_frame_done  <= w_frame_done_next;
            r_overrun     <= w_overrun_next;
            r_frame_clr   <= w_frame_clr_next;
            r_clr_pending <= w_clr_pending_next;
            r_kon_prev    <= w_kon_prev_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_op_sel_next     = r_op_sel;
        w_op_reset_next   = r_op_reset;
        w_restart_next    = r_restart;
        w_kon_next        = r_kon;
        w_busy_next       = r_busy;
        w_frame_done_next = 1'b0;
        w_frame_clr_next  = r_frame_clr;
        w_commit_next     = 1'b0;
        w_slot_load       = 1'b0;
        w_slot_op         = r_op_sel + 6'd1;
        w_slot_clr        = r_frame_clr;
        w_prev_we         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (sample_tick) begin
                    w_state_next     = S_RUN;
                    w_busy_next      = 1'b1;
                    w_op_sel_next    = '0;
                    w_cnt_next       = '0;
                    w_slot_op        = '0;
                    // a clr_req arriving with the tick already counts for this frame
                    w_slot_clr       = r_clr_pending | clr_req;
                    w_frame_clr_next = w_slot_clr;
                    w_slot_load      = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_prev_we = 1'b1;
                    if (r_op_sel == LAST_OP) begin
                        w_state_next      = S_IDLE;
                        w_busy_next       = 1'b0;
                        w_frame_done_next = 1'b1;
                        w_op_sel_next     = '0;
                        w_cnt_next        = '0;
                        w_kon_next        = 1'b0;
                        w_restart_next    = 1'b0;
                        w_op_reset_next   = 1'b0;
                    end else begin
                        w_op_sel_next = w_slot_op;
                        w_cnt_next    = '0;
                        w_slot_load   = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // slot outputs are captured once at slot start and held for the whole slot
        if (w_slot_load) begin
            w_kon_next      = kon_ch[w_slot_op[5:1]];
            w_restart_next  = ~w_slot_clr & w_kon_next & ~r_kon_prev[w_slot_op];
            w_op_reset_next = w_slot_clr;
        end

        if (w_state_next == S_RUN && w_cnt_next == LAST_CNT) begin
            w_commit_next = 1'b1;
        end
    end

    always_comb begin
        w_clr_pending_next = r_clr_pending;
        if (r_state == S_IDLE && sample_tick) begin
            w_clr_pending_next = 1'b0;
        end else if (clr_req) begin
            w_clr_pending_next = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_kon_prev
            // a clear frame forgets key-on history so a held key restarts afterwards
            assign w_kon_prev_next[gi] = (w_prev_we && r_op_sel == 6'(gi))
                                         ? (r_kon & ~r_frame_clr) : r_kon_prev[gi];
        end
    endgenerate

    assign w_ovr_tick = (r_state == S_RUN) && sample_tick;

`ifdef FM_SEQ_OVERRUN_CNT_EN
    logic [7:0] r_overrun_cnt, w_overrun_cnt_next;
    logic [7:0] w_ocnt_base;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_overrun_cnt <= '0;
        end else begin
            r_overrun_cnt <= w_overrun_cnt_next;
        end
    end

    always_comb begin
        w_ocnt_base        = clr_req ? 8'd0 : r_overrun_cnt;
        w_overrun_cnt_next = w_ocnt_base;
        if (w_ovr_tick && w_ocnt_base != 8'hFF) begin
            w_overrun_cnt_next = w_ocnt_base + 8'd1;
        end
        w_overrun_next = (w_overrun_cnt_next != 8'd0);
    end

    assign overrun_cnt = r_overrun_cnt;
`else
    always_comb begin
        w_overrun_next = r_overrun;
        if (w_ovr_tick) begin
            w_overrun_next = 1'b1;
        end else if (clr_req) begin
            w_overrun_next = 1'b0;
        end
    end
`endif

    assign op_sel     = r_op_sel;
    assign next       = r_commit;
    assign op_reset   = r_op_reset;
    assign restart    = r_restart;
    assign kon        = r_kon;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_fm_op_seq.sv
// Bench for fm_op_seq: frame-arithmetic reference model checked every cycle, plus literal
// per-frame expectations (slot masks, timing offsets) for the directed scenarios.
module tb_fm_op_seq;

    localparam int NO = 36;
    localparam int SC = 4;
    localparam int FL = NO * SC;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            sample_tick = 1'b0;
    logic            clr_req = 1'b0;
    logic [NO/2-1:0] kon_ch = '0;
    logic [5:0]      op_sel;
    logic            next, op_reset, restart, kon, busy, frame_done, overrun;
`ifdef FM_SEQ_OVERRUN_CNT_EN
    logic [7:0]      overrun_cnt;
`endif

    fm_op_seq #(.NUM_OPS(NO), .SLOT_CYCLES(SC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .clr_req     (clr_req),
        .kon_ch      (kon_ch),
        .op_sel      (op_sel),
        .next        (next),
        .op_reset    (op_reset),
        .restart     (restart),
        .kon         (kon),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
`ifdef FM_SEQ_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: position in frame is a plain cycle offset 1..FL
    logic          m_valid = 1'b0;
    logic          m_busy, m_clr, m_pend, m_ovr, m_done, m_kon, m_rs, m_rst;
    logic [NO-1:0] m_prev;
    int            m_c;
    int            m_ocnt;
    logic          ovr_tick, accepted;

    task automatic slot_start(input int op);
        m_kon = kon_ch[op / 2];
        m_rs  = !m_clr && m_kon && !m_prev[op];
        m_rst = m_clr;
    endtask

    // per-frame records of what the DUT showed on each commit
    logic [63:0] rec_restart, rec_kon, rec_reset;
    int          n_next, first_next, last_next, busy_cnt, done_cyc;

    always @(negedge clk) begin
        if (m_valid) begin
            check($sformatf("cycle_outputs@%0d", cyc),
                  {51'd0, busy, op_sel, next, op_reset, restart, kon, frame_done, overrun},
                  {51'd0, m_busy, (m_busy ? 6'((m_c - 1) / SC) : 6'd0), (m_busy && (m_c % SC == 0)),
                   m_rst, m_rs, m_kon, m_done, m_ovr});
`ifdef FM_SEQ_OVERRUN_CNT_EN
            check($sformatf("overrun_cnt@%0d", cyc), {56'd0, overrun_cnt}, 64'(m_ocnt));
`endif
        end
        if (busy) busy_cnt++;
        if (next) begin
            n_next++;
            if (first_next < 0) first_next = cyc;
            last_next = cyc;
            rec_restart[op_sel] = restart;
            rec_kon[op_sel]     = kon;
            rec_reset[op_sel]   = op_reset;
        end
        if (frame_done) done_cyc = cyc;

        if (!reset_n) begin
            m_valid = 1'b1;
            m_busy = 0; m_c = 0; m_clr = 0; m_pend = 1; m_ovr = 0; m_done = 0;
            m_kon = 0; m_rs = 0; m_rst = 0; m_prev = '0; m_ocnt = 0;
        end else if (m_valid) begin
            ovr_tick = m_busy && sample_tick;
            accepted = !m_busy && sample_tick;
            m_done = 0;
            if (m_busy) begin
                if (m_c % SC == 0) m_prev[(m_c - 1) / SC] = m_clr ? 1'b0 : m_kon;
                if (m_c == FL) begin
                    m_busy = 0; m_c = 0; m_done = 1; m_kon = 0; m_rs = 0; m_rst = 0;
                end else begin
                    m_c++;
                    if ((m_c - 1) % SC == 0) slot_start((m_c - 1) / SC);
                end
            end else if (accepted) begin
                m_busy = 1; m_c = 1; m_clr = m_pend | clr_req;
                slot_start(0);
            end
            if (accepted) m_pend = 0;
            else if (clr_req) m_pend = 1;
`ifdef FM_SEQ_OVERRUN_CNT_EN
            if (clr_req) m_ocnt = 0;
            if (ovr_tick && m_ocnt < 255) m_ocnt++;
            m_ovr = (m_ocnt != 0);
`else
            if (ovr_tick) m_ovr = 1;
            else if (clr_req) m_ovr = 0;
`endif
        end
    end

    int t0;

    task automatic do_frame(input logic [NO/2-1:0] kc, input int clr_at, input int ovr_at,
                            input int glitch_at, input bit b2b, input bit flood);
        int off;
        @(posedge clk); #1;
        kon_ch = kc;
        rec_restart = '0; rec_kon = '0; rec_reset = '0;
        n_next = 0; first_next = -1; last_next = -1; busy_cnt = 0; done_cyc = -1;
        sample_tick = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            off = cyc - t0;
            sample_tick = (off == ovr_at) || (b2b && off == FL + 1) ||
                          (flood && off >= 2 && off <= FL - 4);
            clr_req = (off == clr_at);
            kon_ch  = (off == glitch_at) ? '0 : kc;
            if (done_cyc >= 0) break;
        end
        sample_tick = 1'b0;
        clr_req = 1'b0;
        kon_ch = kc;
        check("frame_completed", 64'(done_cyc >= 0), 64'd1);
        if (b2b) begin
            check("b2b_busy_after_done", 64'(busy), 64'd1);
            for (int i = 0; i < 400 && busy; i++) begin
                @(posedge clk); #1;
            end
            check("b2b_second_frame_ends", 64'(busy), 64'd0);
        end
    endtask

    task automatic frame_expect(input string tag, input logic [63:0] e_rs,
                                input logic [63:0] e_kon, input logic [63:0] e_rst);
        check({tag, "_done_offset"}, 64'(done_cyc - t0), 64'd145);
        check({tag, "_first_next"},  64'(first_next - t0), 64'd4);
        check({tag, "_last_next"},   64'(last_next - t0), 64'd144);
        check({tag, "_next_count"},  64'(n_next), 64'd36);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd144);
        check({tag, "_restart_mask"}, rec_restart, e_rs);
        check({tag, "_kon_mask"},     rec_kon, e_kon);
        check({tag, "_reset_mask"},   rec_reset, e_rst);
    endtask

    localparam logic [63:0] ALL  = 64'h0000_000F_FFFF_FFFF;
    localparam logic [63:0] OP67 = 64'h0000_0000_0000_00C0;
    localparam logic [NO/2-1:0] CH3 = 18'h00008;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("reset_outputs", {51'd0, busy, op_sel, next, op_reset, restart, kon, frame_done, overrun}, 64'd0);

        do_frame('0, -1, -1, -1, 0, 0);  frame_expect("f1_init_clear", 64'd0, 64'd0, ALL);
        do_frame(CH3, -1, -1, -1, 0, 0); frame_expect("f2_keyon", OP67, OP67, 64'd0);
        do_frame(CH3, -1, -1, -1, 0, 0); frame_expect("f3_held", 64'd0, OP67, 64'd0);
        do_frame('0, -1, -1, -1, 0, 0);  frame_expect("f4_off", 64'd0, 64'd0, 64'd0);
        do_frame(CH3, -1, -1, -1, 0, 0); frame_expect("f5_reon", OP67, OP67, 64'd0);
        do_frame(CH3, 50, -1, -1, 0, 0); frame_expect("f6_clr_mid", 64'd0, OP67, 64'd0);
        do_frame(CH3, -1, -1, -1, 0, 0); frame_expect("f7_clear", 64'd0, OP67, ALL);
        do_frame(CH3, -1, -1, -1, 0, 0); frame_expect("f8_after_clr", OP67, OP67, 64'd0);
        do_frame(CH3, -1, -1, 26, 0, 0); frame_expect("f9_midslot_glitch", 64'd0, OP67, 64'd0);

        do_frame(CH3, -1, 20, -1, 0, 0); frame_expect("f10_overrun", 64'd0, OP67, 64'd0);
        check("overrun_set", 64'(overrun), 64'd1);
        @(posedge clk); #1 clr_req = 1'b1;
        @(posedge clk); #1 clr_req = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'd0);

        do_frame(CH3, -1, -1, -1, 1, 0);
        check("b2b_no_overrun", 64'(overrun), 64'd0);

        // reset pulse during slot 10 abandons the frame
        @(posedge clk); #1;
        done_cyc = -1; kon_ch = CH3; sample_tick = 1'b1; t0 = cyc;
        @(posedge clk); #1 sample_tick = 1'b0;
        while (cyc < t0 + 41) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        check("midframe_reset_outputs",
              {51'd0, busy, op_sel, next, op_reset, restart, kon, frame_done, overrun}, 64'd0);
        repeat (200) @(posedge clk);
        #1 check("midframe_reset_no_done", 64'(done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        do_frame(CH3, -1, -1, -1, 0, 0); frame_expect("f12_post_reset", 64'd0, OP67, ALL);
        do_frame(CH3, -1, -1, -1, 0, 0); frame_expect("f13_restart", OP67, OP67, 64'd0);

`ifdef FM_SEQ_OVERRUN_CNT_EN
        for (int f = 0; f < 3; f++) do_frame(CH3, -1, -1, -1, 0, 1);
        check("overrun_cnt_saturated", {56'd0, overrun_cnt}, 64'd255);
        check("overrun_with_cnt", 64'(overrun), 64'd1);
        @(posedge clk); #1 clr_req = 1'b1;
        @(posedge clk); #1 clr_req = 1'b0;
        check("overrun_cnt_cleared", {56'd0, overrun_cnt}, 64'd0);
`endif

        repeat (4) @(posedge clk);
        #1 $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
